// File: rtl/exec_done_tracker_pkg.sv
// Shared configuration for the execution-done tracker: active-list geometry,
// sequence-number width and the writeback completion packet.
package exec_done_tracker_pkg;
   localparam int AL_DEPTH     = 16;
   localparam int WB_LANES     = 4;
   localparam int RETIRE_WIDTH = 2;
   localparam int SIZE_SEQ     = 8;
   localparam int AL_ID_W      = $clog2(AL_DEPTH);

   typedef struct packed {
      logic exception;
   } ctrl_flags_t;

   typedef struct packed {
      logic [SIZE_SEQ-1:0] seqNo;
      logic                valid;
      logic [AL_ID_W-1:0]  alID;
      ctrl_flags_t         flags;
   } ctrlPkt;

   // An entry may leave the active list only when it finished cleanly.
   function automatic logic retire_ok(input logic alloc, input logic done, input logic excp);
      return alloc & done & ~excp;
   endfunction
endpackage

// File: rtl/exec_done_retire_sel.sv
// Picks the in-order retire window starting at head: consecutive cleanly
// completed entries, stopping at the first one that cannot leave.
module exec_done_retire_sel #(
   parameter int  AL_DEPTH     = exec_done_tracker_pkg::AL_DEPTH,
   parameter int  RETIRE_WIDTH = exec_done_tracker_pkg::RETIRE_WIDTH,
   localparam int ID_W         = $clog2(AL_DEPTH),
   localparam int CNT_W        = $clog2(RETIRE_WIDTH + 1)
) (
   input  logic [ID_W-1:0]         head_i,
   input  logic [AL_DEPTH-1:0]     alloc_i,
   input  logic [AL_DEPTH-1:0]     done_i,
   input  logic [AL_DEPTH-1:0]     excp_i,
   output logic [RETIRE_WIDTH-1:0] mask_o,
   output logic [CNT_W-1:0]        cnt_o
);
   import exec_done_tracker_pkg::*;

   logic            stop_s;
   logic [ID_W-1:0] idx_s;

   // Walk the window from head; the first blocking entry closes it.
   always_comb begin
      mask_o = '0;
      cnt_o  = '0;
      stop_s = 1'b0;
      idx_s  = head_i;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         idx_s = head_i + ID_W'(i);
         if (!stop_s && retire_ok(alloc_i[idx_s], done_i[idx_s], excp_i[idx_s])) begin
            mask_o[i] = 1'b1;
            cnt_o     = cnt_o + CNT_W'(1);
         end else begin
            stop_s = 1'b1;
         end
      end
   end
endmodule

// File: rtl/exec_done_tracker.sv
// Active-list completion tracker: allocates entries at dispatch, marks them
// done from writeback, retires in order and flags a head exception once.
module exec_done_tracker #(
   parameter int  AL_DEPTH     = exec_done_tracker_pkg::AL_DEPTH,
   parameter int  WB_LANES     = exec_done_tracker_pkg::WB_LANES,
   parameter int  RETIRE_WIDTH = exec_done_tracker_pkg::RETIRE_WIDTH,
   localparam int ID_W         = $clog2(AL_DEPTH),
   localparam int SEQ_W        = exec_done_tracker_pkg::SIZE_SEQ,
   localparam int RCNT_W       = $clog2(RETIRE_WIDTH + 1)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      recoverFlag_i,
   input  logic                                      dispatchValid_i,
   input  logic [SEQ_W-1:0]                          dispatchSeqNo_i,
   output logic [ID_W-1:0]                           alID_o,
   output logic                                      alFull_o,
   input  exec_done_tracker_pkg::ctrlPkt [WB_LANES-1:0] ctrlPacket_i,
   output logic [RETIRE_WIDTH-1:0]                   retireValid_o,
   output logic [RETIRE_WIDTH-1:0][SEQ_W-1:0]        retireSeqNo_o,
   output logic                                      excpValid_o,
   output logic [SEQ_W-1:0]                          excpSeqNo_o,
   output logic [ID_W:0]                             count_o
);
   import exec_done_tracker_pkg::*;

   logic [AL_DEPTH-1:0]                 alloc_q, alloc_d, done_q, done_d, excp_q, excp_d;
   logic [AL_DEPTH-1:0][SEQ_W-1:0]      seq_q, seq_d;
   logic [ID_W-1:0]                     head_q, head_d, tail_q, tail_d;
   logic [ID_W:0]                       count_q, count_d;
   logic                                excp_sent_q, excp_sent_d;
   logic [RETIRE_WIDTH-1:0]             retire_valid_q, retire_valid_d;
   logic [RETIRE_WIDTH-1:0][SEQ_W-1:0]  retire_seq_q, retire_seq_d;
   logic                                excp_valid_q, excp_valid_d;
   logic [SEQ_W-1:0]                    excp_seq_q, excp_seq_d;

   logic [RETIRE_WIDTH-1:0]             ret_mask_s;
   logic [RCNT_W-1:0]                   ret_cnt_s;
   logic                                do_disp_s, lane_hit_s;
   logic [ID_W-1:0]                     ret_idx_s;

   exec_done_retire_sel #(
      .AL_DEPTH     (AL_DEPTH),
      .RETIRE_WIDTH (RETIRE_WIDTH)
   ) u_retire_sel (
      .head_i  (head_q),
      .alloc_i (alloc_q),
      .done_i  (done_q),
      .excp_i  (excp_q),
      .mask_o  (ret_mask_s),
      .cnt_o   (ret_cnt_s)
   );

   assign alID_o        = tail_q;
   assign alFull_o      = (count_q == (ID_W+1)'(AL_DEPTH));
   assign retireValid_o = retire_valid_q;
   assign retireSeqNo_o = retire_seq_q;
   assign excpValid_o   = excp_valid_q;
   assign excpSeqNo_o   = excp_seq_q;
   assign count_o       = count_q;

   // Next-state: completion, then retirement, then dispatch; recovery overrides all.
   always_comb begin
      alloc_d        = alloc_q;
      done_d         = done_q;
      excp_d         = excp_q;
      seq_d          = seq_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      excp_sent_d    = excp_sent_q;
      retire_valid_d = '0;
      retire_seq_d   = '0;
      excp_valid_d   = 1'b0;
      excp_seq_d     = '0;
      lane_hit_s     = 1'b0;
      ret_idx_s      = head_q;
      do_disp_s      = dispatchValid_i & ~alFull_o;

      if (recoverFlag_i) begin
         alloc_d     = '0;
         done_d      = '0;
         excp_d      = '0;
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         excp_sent_d = 1'b0;
      end else begin
         // Completions only land on entries that were allocated before this edge.
         for (int l = 0; l < WB_LANES; l++) begin
            lane_hit_s = ctrlPacket_i[l].valid & alloc_q[ctrlPacket_i[l].alID];
            done_d[ctrlPacket_i[l].alID] = done_d[ctrlPacket_i[l].alID] | lane_hit_s;
            excp_d[ctrlPacket_i[l].alID] = excp_d[ctrlPacket_i[l].alID]
                                           | (lane_hit_s & ctrlPacket_i[l].flags.exception);
         end

         for (int s = 0; s < RETIRE_WIDTH; s++) begin
            ret_idx_s          = head_q + ID_W'(s);
            alloc_d[ret_idx_s] = alloc_d[ret_idx_s] & ~ret_mask_s[s];
            done_d[ret_idx_s]  = done_d[ret_idx_s] & ~ret_mask_s[s];
            retire_seq_d[s]    = ret_mask_s[s] ? seq_q[ret_idx_s] : '0;
         end
         retire_valid_d = ret_mask_s;
         head_d         = head_q + ID_W'(ret_cnt_s);

         if (do_disp_s) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            excp_d[tail_q]  = 1'b0;
            seq_d[tail_q]   = dispatchSeqNo_i;
            tail_d          = tail_q + ID_W'(1);
         end else begin
            tail_d = tail_q;
         end
         count_d = count_q + (ID_W+1)'(do_disp_s) - (ID_W+1)'(ret_cnt_s);

         // Excepting head blocks retirement; report it once until recovery.
         if (alloc_q[head_q] && done_q[head_q] && excp_q[head_q] && !excp_sent_q) begin
            excp_valid_d = 1'b1;
            excp_seq_d   = seq_q[head_q];
            excp_sent_d  = 1'b1;
         end else begin
            excp_sent_d = excp_sent_q;
         end
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         alloc_q        <= '0;
         done_q         <= '0;
         excp_q         <= '0;
         seq_q          <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         excp_sent_q    <= 1'b0;
         retire_valid_q <= '0;
         retire_seq_q   <= '0;
         excp_valid_q   <= 1'b0;
         excp_seq_q     <= '0;
      end else begin
         alloc_q        <= alloc_d;
         done_q         <= done_d;
         excp_q         <= excp_d;
         seq_q          <= seq_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         excp_sent_q    <= excp_sent_d;
         retire_valid_q <= retire_valid_d;
         retire_seq_q   <= retire_seq_d;
         excp_valid_q   <= excp_valid_d;
         excp_seq_q     <= excp_seq_d;
      end
   end
endmodule

// File: tb/tb_exec_done_tracker.sv
// Directed plus randomized bench for exec_done_tracker, checked against a
// queue-based in-order active-list model.
module tb_exec_done_tracker;
   import exec_done_tracker_pkg::*;

   localparam int D   = AL_DEPTH;
   localparam int RW  = RETIRE_WIDTH;
   localparam int L   = WB_LANES;
   localparam int IDW = $clog2(D);
   localparam int SW  = SIZE_SEQ;

   logic                    clk = 1'b0;
   logic                    reset, recover, disp_v;
   logic [SW-1:0]           disp_seq;
   logic [IDW-1:0]          al_id;
   logic                    al_full;
   ctrlPkt [L-1:0]          pkt;
   logic [RW-1:0]           ret_v;
   logic [RW-1:0][SW-1:0]   ret_seq;
   logic                    excp_v;
   logic [SW-1:0]           excp_seq;
   logic [IDW:0]            cnt;

   always #5 clk = ~clk;

   exec_done_tracker dut (
      .clk             (clk),
      .reset           (reset),
      .recoverFlag_i   (recover),
      .dispatchValid_i (disp_v),
      .dispatchSeqNo_i (disp_seq),
      .alID_o          (al_id),
      .alFull_o        (al_full),
      .ctrlPacket_i    (pkt),
      .retireValid_o   (ret_v),
      .retireSeqNo_o   (ret_seq),
      .excpValid_o     (excp_v),
      .excpSeqNo_o     (excp_seq),
      .count_o         (cnt)
   );

   typedef struct { int id; int seq; bit done; bit excp; } ent_t;
   ent_t q[$];
   int   m_tail;
   bit   m_sent;
   int   exp_rv;
   int   exp_rs[RW];
   bit   exp_ev;
   int   exp_es;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_tail = 0;
      m_sent = 1'b0;
      exp_rv = 0;
      for (int s = 0; s < RW; s++) exp_rs[s] = 0;
      exp_ev = 1'b0;
      exp_es = 0;
   endtask

   // Apply one clock edge of the inputs to the reference list.
   task automatic model_edge();
      int n;
      bit full;
      if (reset || recover) begin
         model_reset();
      end else begin
         full = (q.size() == D);
         n = 0;
         while (n < RW && n < q.size() && q[n].done && !q[n].excp) n++;
         exp_ev = 1'b0;
         exp_es = 0;
         if (q.size() > 0 && q[0].done && q[0].excp && !m_sent) begin
            exp_ev = 1'b1;
            exp_es = q[0].seq;
            m_sent = 1'b1;
         end
         for (int l = 0; l < L; l++) begin
            if (pkt[l].valid) begin
               for (int j = 0; j < q.size(); j++) begin
                  if (q[j].id == int'(pkt[l].alID)) begin
                     q[j].done = 1'b1;
                     q[j].excp = q[j].excp | pkt[l].flags.exception;
                  end
               end
            end
         end
         exp_rv = 0;
         for (int s = 0; s < RW; s++) exp_rs[s] = 0;
         for (int s = 0; s < n; s++) begin
            exp_rv = exp_rv | (1 << s);
            exp_rs[s] = q[0].seq;
            void'(q.pop_front());
         end
         if (disp_v && !full) begin
            q.push_back('{id: m_tail, seq: int'(disp_seq), done: 1'b0, excp: 1'b0});
            m_tail = (m_tail + 1) % D;
         end
      end
   endtask

   task automatic clr_strobes();
      disp_v   = 1'b0;
      disp_seq = '0;
      recover  = 1'b0;
      pkt      = '0;
   endtask

   task automatic complete(input int lane, input int id, input bit exc);
      pkt[lane].valid           = 1'b1;
      pkt[lane].alID            = IDW'(id);
      pkt[lane].flags.exception = exc;
   endtask

   task automatic dispatch(input int seq);
      disp_v   = 1'b1;
      disp_seq = SW'(seq);
   endtask

   // One clock: check combinational outputs, edge, check registered outputs.
   task automatic cycle();
      chk("alID", 32'(al_id), 32'(m_tail));
      chk("alFull", 32'(al_full), 32'(q.size() == D));
      @(posedge clk);
      model_edge();
      #1;
      chk("retireValid", 32'(ret_v), 32'(exp_rv));
      for (int s = 0; s < RW; s++) chk("retireSeqNo", 32'(ret_seq[s]), 32'(exp_rs[s]));
      chk("excpValid", 32'(excp_v), 32'(exp_ev));
      chk("excpSeqNo", 32'(excp_seq), 32'(exp_es));
      chk("count", 32'(cnt), 32'(q.size()));
      clr_strobes();
   endtask

   initial begin
      reset = 1'b1;
      clr_strobes();
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      dispatch(99);
      cycle();
      reset = 1'b0;
      chk("reset_count", 32'(cnt), 32'd0);
      chk("reset_alid", 32'(al_id), 32'd0);

      // In-order retirement behind an out-of-order completion stream.
      for (int i = 0; i < 4; i++) begin dispatch(10 + i); cycle(); end
      chk("fill4_count", 32'(cnt), 32'd4);
      for (int i = 3; i >= 0; i--) begin complete(0, i, 1'b0); cycle(); chk("no_early_retire", 32'(ret_v), 32'd0); end
      cycle();
      chk("ret_pair0_v", 32'(ret_v), 32'd3);
      chk("ret_pair0_s0", 32'(ret_seq[0]), 32'd10);
      chk("ret_pair0_s1", 32'(ret_seq[1]), 32'd11);
      chk("ret_pair0_cnt", 32'(cnt), 32'd2);
      cycle();
      chk("ret_pair1_v", 32'(ret_v), 32'd3);
      chk("ret_pair1_s0", 32'(ret_seq[0]), 32'd12);
      chk("ret_pair1_s1", 32'(ret_seq[1]), 32'd13);
      chk("ret_pair1_cnt", 32'(cnt), 32'd0);

      // Full list, ignored dispatch, blocked dispatch during retire, wrap.
      recover = 1'b1; cycle();
      for (int i = 0; i < D; i++) begin dispatch(100 + i); cycle(); end
      chk("full_flag", 32'(al_full), 32'd1);
      chk("full_alid", 32'(al_id), 32'd0);
      dispatch(55); cycle();
      chk("full_ignored_cnt", 32'(cnt), 32'd16);
      complete(1, 0, 1'b0); cycle();
      dispatch(77); cycle();
      chk("full_retire_v", 32'(ret_v), 32'd1);
      chk("full_retire_cnt", 32'(cnt), 32'd15);
      chk("full_released", 32'(al_full), 32'd0);
      chk("wrap_alid", 32'(al_id), 32'd0);
      dispatch(200); cycle();

      // Duplicate-lane completion and completion to an unallocated entry.
      recover = 1'b1; cycle();
      for (int i = 0; i < 6; i++) begin dispatch(20 + i); cycle(); end
      complete(0, 5, 1'b0); complete(2, 5, 1'b0); complete(1, 9, 1'b0); cycle();
      repeat (2) cycle();
      chk("dup_no_retire", 32'(ret_v), 32'd0);
      chk("dup_count", 32'(cnt), 32'd6);
      for (int i = 0; i < 4; i++) complete(i, i, 1'b0);
      cycle();
      complete(3, 4, 1'b0); cycle();
      repeat (4) cycle();
      chk("dup_drained", 32'(cnt), 32'd0);

      // Head exception: single pulse, stall, recovery.
      recover = 1'b1; cycle();
      dispatch(40); cycle();
      dispatch(41); cycle();
      complete(0, 0, 1'b1); complete(1, 1, 1'b0); cycle();
      cycle();
      chk("excp_pulse", 32'(excp_v), 32'd1);
      chk("excp_seq", 32'(excp_seq), 32'd40);
      chk("excp_no_retire", 32'(ret_v), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("excp_no_repeat", 32'(excp_v), 32'd0);
         chk("excp_stalled", 32'(ret_v), 32'd0);
      end
      recover = 1'b1; cycle();
      chk("recover_cnt", 32'(cnt), 32'd0);
      chk("recover_alid", 32'(al_id), 32'd0);

      // Recovery beats a concurrent dispatch and completion.
      dispatch(60); cycle();
      dispatch(61); cycle();
      complete(0, 0, 1'b0); dispatch(62); recover = 1'b1; cycle();
      chk("rec_wins_cnt", 32'(cnt), 32'd0);
      chk("rec_wins_ret", 32'(ret_v), 32'd0);
      chk("rec_wins_alid", 32'(al_id), 32'd0);
      dispatch(63); cycle();

      // Reset in the middle of pending work and an imminent retirement.
      recover = 1'b1; cycle();
      for (int i = 0; i < 8; i++) begin dispatch(80 + i); cycle(); end
      complete(0, 0, 1'b0); complete(1, 1, 1'b0); cycle();
      reset = 1'b1; dispatch(90); complete(2, 2, 1'b0); cycle();
      reset = 1'b0;
      chk("midreset_ret", 32'(ret_v), 32'd0);
      chk("midreset_cnt", 32'(cnt), 32'd0);
      chk("midreset_excp", 32'(excp_v), 32'd0);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 99) < 60) dispatch(int'($urandom_range(0, 255)));
         for (int l = 0; l < L; l++) begin
            if ($urandom_range(0, 99) < 40) begin
               if (q.size() > 0 && $urandom_range(0, 3) != 0)
                  complete(l, q[$urandom_range(0, q.size() - 1)].id, $urandom_range(0, 99) < 3);
               else
                  complete(l, int'($urandom_range(0, D - 1)), $urandom_range(0, 99) < 3);
            end
         end
         if ((m_sent && $urandom_range(0, 9) < 3) || $urandom_range(0, 199) == 0) recover = 1'b1;
         reset = ($urandom_range(0, 299) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
